// File: rtl/mem_pkg.sv
// Shared constants and state encoding for the block-level main-memory model
// that backs the set-associative cache.
package mem_pkg;

  localparam int word_size        = 32;
  localparam int words_per_block  = 4;
  localparam int block_addr_width = 28;
  localparam int block_width      = word_size * words_per_block;

  // Wide enough for any legal latency (1..15).
  localparam int counter_width    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_latency_counter.sv
// Down-counter that times a memory transaction: loaded on accept, counts
// down while busy, and flags done when it has reached zero in the busy state.
module mem_latency_counter
  import mem_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [counter_width-1:0] load_value,
  input  logic                     busy,
  output logic                     done
);

  logic [counter_width-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (busy && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = busy && (count_reg == '0);

endmodule

// File: rtl/block_memory.sv
// Block-granular main memory with fixed access latency; one whole cache block
// is read or written per request. Define MEM_PRELOAD_EN to preload word w of
// entry i with i*words_per_block + w; otherwise contents start undefined.
module block_memory
  import mem_pkg::*;
#(
  parameter int depth   = 256,
  parameter int latency = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        read,
  input  logic                        write,
  input  logic [block_addr_width-1:0] address,
  input  logic [block_width-1:0]      writedata,
  output logic [block_width-1:0]      readdata,
  output logic                        busywait
);

  localparam int index_width = $clog2(depth);
  localparam logic [counter_width-1:0] latency_load = counter_width'(latency - 1);

  state_t                   state_reg, state_next;
  logic                     accept;
  logic                     complete;
  logic                     counter_done;
  logic [index_width-1:0]   index_reg;
  logic                     op_write_reg;
  logic [block_width-1:0]   wdata_reg;
  logic                     mem_we;
  logic                     mem_rd;

  // Upper address bits simply alias onto the stored entries.
  logic addr_unused;
  assign addr_unused = ^address[block_addr_width-1:index_width];

`ifdef MEM_PRELOAD_EN
  typedef logic [block_width-1:0] mem_array_t [depth];

  function automatic mem_array_t preload_image();
    mem_array_t img;
    for (int i = 0; i < depth; i++) begin
      for (int w = 0; w < words_per_block; w++) begin
        img[i][w*word_size +: word_size] = word_size'(i * words_per_block + w);
      end
    end
    return img;
  endfunction

  mem_array_t mem = preload_image();
`else
  logic [block_width-1:0] mem [depth];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    complete   = 1'b0;
    busywait   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (read || write) begin
          accept     = 1'b1;
          busywait   = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        busywait = 1'b1;
        if (counter_done) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request is captured once so later input changes cannot disturb it;
  // write takes priority when both strobes are high.
  always_ff @(posedge clk) begin
    if (accept) begin
      index_reg    <= address[index_width-1:0];
      op_write_reg <= write;
      wdata_reg    <= writedata;
    end
  end

  assign mem_we = complete && op_write_reg;
  assign mem_rd = complete && !op_write_reg;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[index_reg] <= wdata_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (mem_rd) begin
      readdata <= mem[index_reg];
    end
  end

  mem_latency_counter u_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .load_value (latency_load),
    .busy       (state_reg == BUSY),
    .done       (counter_done)
  );

endmodule
